video_stream_checker: RTL and testbench

VIDEO_STREAM_CHECKER -- requirements
Module: video_stream_checker

---
 rtl/video_stream_checker.sv | 215 +++++++++++++++++++++
 tb/tb_video_stream_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_checker.sv
// ============================================================================
// Module   : video_stream_checker
// Purpose  : Compares a DUV video stream against a delayed golden stream and
//            reports pixel mismatches and timing errors for one frame.
//            Optional frame CRC when VIDEO_CHECKER_CRC_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module video_stream_checker #(
  parameter int HRES      = 1600,
  parameter int VRES      = 900,
  parameter int CH        = 3,
  parameter int BPC       = 8,
  parameter int TOL_SHIFT = 1,
  parameter int LAT       = 1,
  parameter int ECW       = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ref_dv,
  input  logic                ref_hs,
  input  logic                ref_vs,
  input  logic [CH*BPC-1:0]   ref_pix,
  input  logic                duv_dv,
  input  logic                duv_hs,
  input  logic                duv_vs,
  input  logic [CH*BPC-1:0]   duv_pix,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ECW-1:0]      err_cnt,
  output logic                sync_err,
  output logic [10:0]         first_col,
  output logic [10:0]         first_row
`ifdef VIDEO_CHECKER_CRC_EN
  ,
  output logic [15:0]         frame_crc
`endif
);

  localparam int              c_pix_w    = CH * BPC;
  localparam int              c_dly_w    = c_pix_w + 3;
  localparam logic [10:0]     c_col_last = 11'(HRES - 1);
  localparam logic [10:0]     c_row_last = 11'(VRES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CHECK   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_done_next;

  logic [c_dly_w-1:0]   r_dly [LAT];
  logic                 r_prev_vs;
  logic                 r_done;
  logic [ECW-1:0]       r_err_cnt;
  logic                 r_sync_err;
  logic [10:0]          r_first_col;
  logic [10:0]          r_first_row;
  logic [10:0]          r_col;
  logic [10:0]          r_row;

  logic                 w_dly_dv;
  logic                 w_dly_hs;
  logic                 w_dly_vs;
  logic [c_pix_w-1:0]   w_dly_pix;
  logic                 w_vs_fall;
  logic                 w_last;
  logic                 w_enter_wait;
  logic                 w_check_px;
  logic [CH-1:0]        w_ch_mis;
  logic                 w_pix_mis;
  logic                 w_sync_mis;

  // Golden timing and pixel travel together so they stay aligned with the DUV
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= {ref_dv, ref_hs, ref_vs, ref_pix};
      for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_dly_dv  = r_dly[LAT-1][c_dly_w-1];
  assign w_dly_hs  = r_dly[LAT-1][c_dly_w-2];
  assign w_dly_vs  = r_dly[LAT-1][c_dly_w-3];
  assign w_dly_pix = r_dly[LAT-1][c_pix_w-1:0];

  assign w_vs_fall    = r_prev_vs & ~w_dly_vs;
  assign w_last       = (r_col == c_col_last) && (r_row == c_row_last);
  assign w_enter_wait = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_check_px   = (r_state == S_CHECK) && w_dly_dv;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign w_ch_mis[c] = (duv_pix[c*BPC +: BPC] >> TOL_SHIFT) !=
                         (w_dly_pix[c*BPC +: BPC] >> TOL_SHIFT);
  end

  assign w_pix_mis  = w_check_px && (|w_ch_mis);
  assign w_sync_mis = (r_state == S_CHECK) &&
                      ({duv_dv, duv_hs, duv_vs} != {w_dly_dv, w_dly_hs, w_dly_vs});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_WAIT_VS;
      S_WAIT_VS: if (w_vs_fall) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_dly_dv && w_last) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end
      end
      S_DONE:    if (start) w_state_next = S_WAIT_VS;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // done is registered so a mismatch on the last pixel is already counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_vs   <= 1'b0;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_sync_err  <= 1'b0;
      r_first_col <= '0;
      r_first_row <= '0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      r_prev_vs <= w_dly_vs;
      r_done    <= w_done_next;
      if (w_enter_wait) begin
        r_err_cnt   <= '0;
        r_sync_err  <= 1'b0;
        r_first_col <= '0;
        r_first_row <= '0;
        r_col       <= '0;
        r_row       <= '0;
      end else begin
        if (w_sync_mis) r_sync_err <= 1'b1;
        if (w_pix_mis) begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          if (r_err_cnt == '0) begin
            r_first_col <= r_col;
            r_first_row <= r_row;
          end
        end
        if (w_check_px) begin
          if (r_col == c_col_last) begin
            r_col <= '0;
            r_row <= r_row + 11'd1;
          end else begin
            r_col <= r_col + 11'd1;
          end
        end
      end
    end
  end

  assign busy      = (r_state == S_WAIT_VS) || (r_state == S_CHECK);
  assign done      = r_done;
  assign pass      = (r_state == S_DONE) && (r_err_cnt == '0) && !r_sync_err;
  assign err_cnt   = r_err_cnt;
  assign sync_err  = r_sync_err;
  assign first_col = r_first_col;
  assign first_row = r_first_row;

`ifdef VIDEO_CHECKER_CRC_EN
  localparam int c_bytes = (c_pix_w + 7) / 8;

  logic [15:0] r_crc;

  // CRC-16-CCITT, MSB-first within each byte, pixel bytes fed LSB byte first
  function automatic logic [15:0] f_crc_px(input logic [15:0] crc,
                                           input logic [c_pix_w-1:0] pix);
    logic [15:0]          v;
    logic [c_bytes*8-1:0] p;
    v = crc;
    p = '0;
    p[c_pix_w-1:0] = pix;
    for (int b = 0; b < c_bytes; b++) begin
      v = v ^ {p[b*8 +: 8], 8'h00};
      for (int i = 0; i < 8; i++) begin
        v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
      end
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_crc <= 16'hFFFF;
    else if (w_enter_wait) r_crc <= 16'hFFFF;
    else if (w_check_px)   r_crc <= f_crc_px(r_crc, duv_pix);
  end

  assign frame_crc = r_crc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_stream_checker.sv
// ============================================================================
// Module   : tb_video_stream_checker
// Purpose  : Directed and randomized frames against a cycle-level behavioural
//            model of the checker; small HRES/VRES, LAT=2, ECW=2.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_stream_checker;
  localparam int HRES = 4, VRES = 2, CH = 3, BPC = 8, TOL = 1, LAT = 2, ECW = 2;
  localparam int PW = CH * BPC, NMAX = 256, NPIX = HRES * VRES;
  localparam int M_IDLE = 0, M_WAIT = 1, M_CHECK = 2, M_DONE = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic ref_dv = 0, ref_hs = 0, ref_vs = 0, duv_dv = 0, duv_hs = 0, duv_vs = 0;
  logic [PW-1:0] ref_pix = '0, duv_pix = '0;
  logic busy, done, pass, sync_err;
  logic [ECW-1:0] err_cnt;
  logic [10:0] first_col, first_row;

  video_stream_checker #(
    .HRES(HRES), .VRES(VRES), .CH(CH), .BPC(BPC),
    .TOL_SHIFT(TOL), .LAT(LAT), .ECW(ECW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ref_dv(ref_dv), .ref_hs(ref_hs), .ref_vs(ref_vs), .ref_pix(ref_pix),
    .duv_dv(duv_dv), .duv_hs(duv_hs), .duv_vs(duv_vs), .duv_pix(duv_pix),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .sync_err(sync_err), .first_col(first_col), .first_row(first_row)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic st; logic dv; logic hs; logic vs; logic [PW-1:0] pix;
  } cyc_t;

  cyc_t f_ref [NMAX];
  cyc_t f_duv [NMAX];
  int   f_len;
  int   pix_t [NPIX];

  int n_tests = 0, n_fail = 0, n_done = 0;

  function automatic void check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: frame pixel index k, integer error count, queue delay
  cyc_t mq[$];
  int   mst, nerr, k, mfc, mfr;
  bit   msync, mprev_vs, mdone;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < LAT; i++) mq.push_back('0);
    mst = M_IDLE; nerr = 0; k = 0; mfc = 0; mfr = 0;
    msync = 0; mprev_vs = 0; mdone = 0;
  endfunction

  function automatic void model_step();
    cyc_t d, cur;
    bit   fall;
    d    = mq[0];
    fall = mprev_vs && !d.vs;
    mdone = 0;
    case (mst)
      M_IDLE, M_DONE: if (start) begin
        mst = M_WAIT; nerr = 0; k = 0; mfc = 0; mfr = 0; msync = 0;
      end
      M_WAIT: if (fall) mst = M_CHECK;
      default: begin
        if ({duv_dv, duv_hs, duv_vs} != {d.dv, d.hs, d.vs}) msync = 1;
        if (d.dv) begin
          if (((duv_pix ^ d.pix) & 24'hFEFEFE) != 0) begin
            if (nerr == 0) begin mfc = k % HRES; mfr = k / HRES; end
            nerr++;
          end
          k++;
          if (k == NPIX) begin mst = M_DONE; mdone = 1; end
        end
      end
    endcase
    mprev_vs = d.vs;
    cur = '0;
    cur.dv = ref_dv; cur.hs = ref_hs; cur.vs = ref_vs; cur.pix = ref_pix;
    void'(mq.pop_front());
    mq.push_back(cur);
  endfunction

  always @(negedge clk) begin
    if (rst) model_reset();
    check("busy",      busy,      (mst == M_WAIT || mst == M_CHECK));
    check("done",      done,      mdone);
    check("pass",      pass,      (mst == M_DONE && nerr == 0 && !msync));
    check("err_cnt",   err_cnt,   (nerr > 3) ? 3 : nerr);
    check("sync_err",  sync_err,  msync);
    check("first_col", first_col, mfc);
    check("first_row", first_row, mfr);
    if (done) n_done++;
    if (!rst) model_step();
  end

  task automatic build_frame(input int gap_max, input bit noise);
    int n;
    for (int i = 0; i < NMAX; i++) begin f_ref[i] = '0; f_duv[i] = '0; end
    f_ref[0].st = 1'b1;
    n = 1;
    for (int i = 0; i < 3; i++) begin f_ref[n].vs = 1'b1; n++; end
    n += 2;
    for (int r = 0; r < VRES; r++) begin
      f_ref[n].hs = 1'b1;
      n += 2;
      for (int c = 0; c < HRES; c++) begin
        n += $urandom_range(0, gap_max);
        f_ref[n].dv  = 1'b1;
        f_ref[n].pix = 24'($urandom);
        pix_t[r*HRES + c] = n;
        n++;
      end
      n++;
    end
    n += 4;
    f_len = n + LAT + 2;
    for (int t = LAT; t < f_len; t++) begin
      f_duv[t] = f_ref[t-LAT];
      f_duv[t].st = 1'b0;
    end
    if (noise)
      for (int i = 0; i < NPIX; i++)
        f_duv[pix_t[i]+LAT].pix ^= 24'($urandom) & 24'h010101;
  endtask

  task automatic corrupt(input int idx);
    f_duv[pix_t[idx]+LAT].pix ^= 24'h000080 << (8 * $urandom_range(0, 2));
  endtask

  task automatic hs_early();
    for (int t = 0; t + LAT < f_len; t++)
      if (f_ref[t].hs) begin
        f_duv[t+LAT].hs   = 1'b0;
        f_duv[t+LAT-1].hs = 1'b1;
      end
  endtask

  task automatic play(input int lim);
    for (int t = 0; t < lim; t++) begin
      @(posedge clk); #1;
      start  = f_ref[t].st;
      ref_dv = f_ref[t].dv; ref_hs = f_ref[t].hs; ref_vs = f_ref[t].vs; ref_pix = f_ref[t].pix;
      duv_dv = f_duv[t].dv; duv_hs = f_duv[t].hs; duv_vs = f_duv[t].vs; duv_pix = f_duv[t].pix;
    end
    @(posedge clk); #1;
    start = 0; ref_dv = 0; ref_hs = 0; ref_vs = 0; ref_pix = '0;
    duv_dv = 0; duv_hs = 0; duv_vs = 0; duv_pix = '0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    settle();
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_err",  err_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Clean frame: exactly one done, pass
    d0 = n_done;
    build_frame(0, 0); play(f_len); settle();
    check("clean_done_cnt", n_done - d0, 1);
    check("clean_pass", pass, 1);
    check("clean_err",  err_cnt, 0);

    // LSB-only differences fall inside the tolerance
    build_frame(1, 1);
    f_ref[pix_t[0]].pix     = 24'h0302FF;
    f_duv[pix_t[0]+LAT].pix = 24'h0203FE;
    play(f_len); settle();
    check("tol_err",  err_cnt, 0);
    check("tol_pass", pass, 1);

    // Two corrupted pixels: (2,0) and (1,1)
    build_frame(1, 0); corrupt(2); corrupt(5); play(f_len); settle();
    check("bad_err",  err_cnt, 2);
    check("bad_col",  first_col, 2);
    check("bad_row",  first_row, 0);
    check("bad_pass", pass, 0);

    // hs one cycle early on the DUV side
    build_frame(0, 0); hs_early(); play(f_len); settle();
    check("hs_sync", sync_err, 1);
    check("hs_pass", pass, 0);
    check("hs_err",  err_cnt, 0);

    // Saturation at 2^ECW-1, then restart from DONE
    build_frame(0, 0);
    corrupt(1); corrupt(2); corrupt(3); corrupt(5); corrupt(7);
    play(f_len); settle();
    check("sat_err", err_cnt, 3);
    check("sat_col", first_col, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    settle();
    check("restart_busy", busy, 1);
    check("restart_err",  err_cnt, 0);

    // Reset in the middle of a frame, with an error already logged
    d0 = n_done;
    build_frame(1, 0); corrupt(1); play(f_len / 2 + 4);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err",  err_cnt, 0);
    check("mid_rst_col",  first_col, 0);
    check("mid_rst_sync", sync_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    settle();
    check("mid_rst_no_done", n_done - d0, 0);

    // Fresh frame after reset checks clean
    d0 = n_done;
    build_frame(2, 1); play(f_len); settle();
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_pass", pass, 1);

    // Randomized frames, checked only by the model
    for (int f = 0; f < 12; f++) begin
      build_frame(3, 1'($urandom_range(0, 1)));
      for (int i = 0; i < NPIX; i++) if ($urandom_range(0, 3) == 0) corrupt(i);
      if ($urandom_range(0, 3) == 0) hs_early();
      if ($urandom_range(0, 2) == 0) f_ref[pix_t[3]].st = 1'b1;
      play(f_len);
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
